// File: rtl/vram_slot_arbiter.sv
// vram_slot_arbiter: time-sliced sharing of one VRAM port between display scanout and a CPU port
module vram_slot_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_en,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              slot,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  typedef enum logic [1:0] {C_IDLE, C_BUSY, C_ACK} cstate_t;
  cstate_t state, state_nx;
  logic g_disp, g_cpu, disp_p1, busy_rd;
  // slot phase and fixed two-cycle display fetch pipeline
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      slot <= 1'b0;
      disp_p1 <= 1'b0;
      disp_valid <= 1'b0;
      disp_data <= '0;
    end else begin
      slot <= ~slot;
      disp_p1 <= g_disp;
      disp_valid <= disp_p1;
      if (disp_p1) disp_data <= ram_rdata;
    end
  // CPU access state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= C_IDLE;
    else state <= state_nx;
  // remember access direction and capture CPU read data one cycle after grant
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      busy_rd <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      if (g_cpu) busy_rd <= ~cpu_we;
      if (state == C_BUSY && busy_rd) cpu_rdata <= ram_rdata;
    end
  // CPU access sequencing: grant, data cycle, ack cycle
  always_comb
    state_nx = state == C_BUSY ? C_ACK : state == C_ACK ? C_IDLE : g_cpu ? C_BUSY : C_IDLE;
  // slot grants and RAM port steering; nothing is granted while reset is held
  always_comb begin
    g_disp = !reset && !slot && disp_en;
    g_cpu = !reset && state == C_IDLE && cpu_req && (slot || !disp_en);
    cpu_ack = state == C_ACK;
    ram_addr = g_disp ? disp_addr : g_cpu ? cpu_addr : '0;
    ram_we = g_cpu && cpu_we;
    ram_wdata = g_cpu ? cpu_wdata : '0;
  end
endmodule

// File: tb/tb_vram_slot_arbiter.sv
// tb_vram_slot_arbiter: randomized check of the VRAM slot arbiter against a cycle-count reference model
module tb_vram_slot_arbiter;
  logic clk = 0, reset = 1;
  logic disp_en = 0, cpu_req = 0, cpu_we = 0;
  logic [9:0] disp_addr = 0, cpu_addr = 0, ram_addr;
  logic [7:0] cpu_wdata = 0, disp_data, cpu_rdata, ram_wdata, ram_rdata;
  logic disp_valid, cpu_ack, slot, ram_we;
  logic [7:0] mem [1024];
  logic [7:0] shadow [1024];
  bit edv [64], eak [64], erv [64];
  logic [7:0] edd [64], erd [64];
  logic [7:0] dd, rd;
  int total = 0, bad = 0, n = 0, free_at = 0;
  bit acked = 0;

  vram_slot_arbiter dut (
    .clk(clk), .reset(reset), .disp_en(disp_en), .disp_addr(disp_addr),
    .disp_data(disp_data), .disp_valid(disp_valid), .cpu_req(cpu_req),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .slot(slot), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  task automatic drive(input int md);
    if (md == 1) begin
      disp_en = 1; disp_addr = 10'h005; cpu_req = 0;
    end else if (md == 2) begin
      disp_en = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 10'h001;
    end else begin
      disp_en = md == 3 ? 1'b1 : $urandom_range(0, 2) != 0;
      disp_addr = 10'($urandom_range(0, 15));
      if (acked || !cpu_req) begin
        cpu_req = $urandom_range(0, 2) != 0;
        cpu_we = 1'($urandom);
        cpu_addr = md == 3 ? 10'h010 : 10'($urandom_range(0, 15));
        cpu_wdata = 8'($urandom);
      end
    end
  endtask

  task automatic model_check();
    int k;
    bit gd, gc;
    if (reset) begin
      n = 0; free_at = 0; dd = 0; rd = 0;
      foreach (edv[i]) begin edv[i] = 0; eak[i] = 0; erv[i] = 0; end
      chk("rst_slot", slot, 0);
      chk("rst_we", ram_we, 0);
      chk("rst_addr", ram_addr, 0);
      chk("rst_ack", cpu_ack, 0);
      chk("rst_dvalid", disp_valid, 0);
      chk("rst_ddata", disp_data, 0);
      chk("rst_rdata", cpu_rdata, 0);
      return;
    end
    k = n % 64;
    gd = n % 2 == 0 && disp_en;
    gc = n >= free_at && cpu_req && (n % 2 == 1 || !disp_en);
    if (edv[k]) dd = edd[k];
    if (eak[k] && erv[k]) rd = erd[k];
    chk("slot", slot, n % 2);
    chk("ram_we", ram_we, gc && cpu_we);
    chk("ram_addr", ram_addr, gd ? disp_addr : gc ? cpu_addr : 0);
    if (gc && cpu_we) chk("ram_wdata", ram_wdata, cpu_wdata);
    chk("disp_valid", disp_valid, edv[k]);
    chk("disp_data", disp_data, dd);
    chk("cpu_ack", cpu_ack, eak[k]);
    chk("cpu_rdata", cpu_rdata, rd);
    edv[k] = 0; eak[k] = 0; erv[k] = 0;
    if (gd) begin
      edv[(n + 2) % 64] = 1;
      edd[(n + 2) % 64] = shadow[disp_addr];
    end
    if (gc) begin
      eak[(n + 2) % 64] = 1;
      erv[(n + 2) % 64] = !cpu_we;
      erd[(n + 2) % 64] = shadow[cpu_addr];
      free_at = n + 3;
      if (cpu_we) shadow[cpu_addr] = cpu_wdata;
    end
    n++;
  endtask

  task automatic cycle(input bit rst_v, input int md);
    @(posedge clk);
    #1;
    reset = rst_v;
    drive(md);
    @(negedge clk);
    model_check();
    acked = cpu_ack;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 8'($urandom);
      shadow[i] = mem[i];
    end
    mem[5] = 8'hA5; shadow[5] = 8'hA5;
    mem[1] = 8'h11; shadow[1] = 8'h11;
    for (int i = 0; i < 3; i++) cycle(1, 0);
    for (int i = 0; i < 20; i++) cycle(0, 1);
    chk("dir_disp_data", disp_data, 8'hA5);
    for (int i = 0; i < 20; i++) cycle(0, 2);
    chk("dir_cpu_rdata", cpu_rdata, 8'h11);
    for (int i = 0; i < 300; i++) cycle(0, 3);
    for (int i = 0; i < 3000; i++) cycle($urandom_range(0, 39) == 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
